display_scheduler: RTL
======================

# display_scheduler

Owns the single VGA RGB path and decides, frame by frame, which screen source drives it: the welcome screen, the text terminal or the game canvas. It sits between the screen generators and the VGA controller. It cuts from welcome to terminal once the welcome animation finishes. It runs a top-down vertical wipe whenever the game request toggles between terminal and game. All switching is aligned to frame boundaries, so no frame ever shows a torn source change.

## Interface
- `V_ACTIVE`, 480: visible lines; `v_addr >= V_ACTIVE` is blanking.
- `H_ACTIVE`, 640: visible columns; `h_addr >= H_ACTIVE` is blanking.
- `WIPE_STEP`, 8: lines the wipe boundary advances per frame; legal range 1..V_ACTIVE.
- `clk`  in  1  pixel clock, same clock as the VGA controller.
- `rst_n`  in  1  synchronous, active-low reset.
- `h_addr`  in  10  current pixel column from the VGA controller.
- `v_addr`  in  10  current pixel row from the VGA controller.
- `rgb_welcome`  in  24  welcome screen pixel.
- `in_welcome`  in  1  high while the welcome screen is running.
- `rgb_term`  in  24  terminal pixel.
- `rgb_game`  in  24  game pixel.
- `game_req`  in  1  level request: 1 means show game, 0 means show terminal.
- `rgb_out`  out  24  registered pixel to the VGA controller.
- `active_src`  out  2  source currently owning the screen: 0 welcome, 1 terminal, 2 game; never 3.
- `busy`  out  1  high while a wipe is in progress.

## Operation
- **Frame tick**
  - `v_addr` is registered into `v_prev`.
  - `frame_tick = (v_prev != 0) && (v_addr == 0)`, one cycle wide.
  - All state and `wipe_line` changes happen only on the clock edge that ends a tick cycle.
- **States:** WELCOME, TERM, GAME, WIPE. WIPE holds two registers:
  - `old_src`: the source being replaced.
  - `new_src`: the target source.
- **WELCOME**
  - Pixel source is `rgb_welcome`.
  - On a tick with `in_welcome == 0`, go to TERM with a hard cut (the welcome screen handles its own exit scroll).
  - `game_req` is ignored in this state.
- **TERM**
  - Pixel source is `rgb_term`.
  - On a tick with `game_req == 1`, go to WIPE with `old_src = 1`, `new_src = 2`, `wipe_line = 0`.
- **GAME**
  - Pixel source is `rgb_game`.
  - On a tick with `game_req == 0`, go to WIPE with `old_src = 2`, `new_src = 1`, `wipe_line = 0`.
- **WIPE**
  - Pixel source is `new_src` when `v_addr < wipe_line`, otherwise `old_src`.
  - On each tick, compute the 11-bit sum `wipe_line + WIPE_STEP`:
    - If the sum is `>= V_ACTIVE`: go to the `new_src` state and clear `wipe_line` to 0.
    - Otherwise: `wipe_line` takes the sum.
  - `game_req` is ignored during a wipe. It is re-sampled as a level at the first tick after the wipe completes, so a request that reverted mid-wipe causes an immediate reverse wipe.
- **One-shot welcome:** after leaving WELCOME, `in_welcome` is ignored until the next reset.
- **Outputs**
  - `active_src` equals the current state's source. During WIPE it equals `old_src` and switches to `new_src` in the same edge that leaves WIPE.
  - `busy = (state == WIPE)`.
- **Blanking:** if `h_addr >= H_ACTIVE` or `v_addr >= V_ACTIVE`, `rgb_out` is `24'h000000` regardless of state.

## Timing
- **Reset**, while `rst_n == 0` at a clock edge:
  - state WELCOME, `wipe_line` 0, `v_prev` 0.
  - `rgb_out` 0, `active_src` 0, `busy` 0.
- **Reset mid-wipe:** the wipe is abandoned and the block returns to WELCOME.
- **First tick after reset:** because `v_prev` resets to 0, no tick can occur until `v_addr` has been non-zero for at least one cycle.
- **Pixel latency:** `rgb_out` at edge N+1 reflects `h_addr`, `v_addr`, the source RGB inputs and the state, all sampled at edge N. Latency is exactly 1 cycle.
- **State change:** visible in `rgb_out` from the first pixel of the new frame, `(0,0)`, plus the 1-cycle latency.
- **Wipe duration:** `ceil(V_ACTIVE / WIPE_STEP)` ticks. For the defaults this is 60 frames.
  - Frame k (k = 0..59) shows the new source on lines `0 .. 8k-1`.
  - Frame 0 of the wipe is entirely the old source.
- **Request timing:** a `game_req` change between ticks is acted on at the next tick only. A pulse shorter than one frame that misses the tick is lost; this is by design.

## Test plan
- **Reset / welcome exit:** reset with `in_welcome = 1`, run 3 frames.
  - `rgb_out` equals `rgb_welcome` (e.g. `24'hD2C4C1`) in the active area and `24'h000000` at `h_addr = 700`; `active_src = 0`.
  - Drop `in_welcome`: from the next frame `rgb_out = rgb_term` and `active_src = 1`.
- **Welcome ignores game:** set `game_req = 1` while in WELCOME.
  - No wipe starts and `busy` stays 0.
  - After welcome exits, the first tick in TERM starts a wipe toward game.
- **Wipe profile:** from TERM, raise `game_req`.
  - `busy = 1` for exactly 60 ticks.
  - In wipe frame 10, line 79 is `rgb_game` and line 80 is `rgb_term`.
  - After the wipe, `active_src = 2` and `busy = 0`.
- **Mid-wipe revert:** drop `game_req` at wipe frame 20.
  - The wipe still completes to GAME.
  - On the next tick a reverse wipe toward TERM begins, with `active_src = 2` and `busy = 1`.
- **Odd step:** with `WIPE_STEP = 7`, the wipe lasts 69 ticks and the last partial frame shows the new source on lines 0..475.
- **Reset mid-wipe:** assert `rst_n = 0` at wipe frame 30.
  - Next cycle: `rgb_out = 0`, `active_src = 0`, `busy = 0`.
  - The block is back in WELCOME.

Source files
------------

// File: rtl/display_scheduler.sv
// Frame-aligned owner of the VGA RGB path: welcome screen, text terminal or game
// canvas, with a top-down vertical wipe between terminal and game.
module display_scheduler #(
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned WIPE_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic [23:0] rgb_welcome,
    input  logic        in_welcome,
    input  logic [23:0] rgb_term,
    input  logic [23:0] rgb_game,
    input  logic        game_req,
    output logic [23:0] rgb_out,
    output logic [1:0]  active_src,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_WELCOME,
        ST_TERM,
        ST_GAME,
        ST_WIPE
    } state_e;

    typedef enum logic [1:0] {
        SRC_WELCOME = 2'd0,
        SRC_TERM    = 2'd1,
        SRC_GAME    = 2'd2
    } src_e;

    localparam logic [9:0]  H_LIM  = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
    localparam logic [10:0] V_LIM11 = 11'(V_ACTIVE);
    localparam logic [10:0] STEP11  = 11'(WIPE_STEP);

    state_e      state_q, state_d;
    src_e        old_src_q, old_src_d;
    src_e        new_src_q, new_src_d;
    logic [9:0]  wipe_line_q, wipe_line_d;
    logic [9:0]  v_prev_q;
    logic [23:0] rgb_q, rgb_d;

    logic        frame_tick;
    logic [10:0] wipe_sum;
    src_e        pix_src;

    assign frame_tick = (v_prev_q != '0) && (v_addr == '0);
    assign wipe_sum   = {1'b0, wipe_line_q} + STEP11;

    always_comb begin
        state_d     = state_q;
        old_src_d   = old_src_q;
        new_src_d   = new_src_q;
        wipe_line_d = wipe_line_q;
        if (frame_tick) begin
            unique case (state_q)
                ST_WELCOME: begin
                    if (!in_welcome) begin
                        state_d = ST_TERM;
                    end
                end
                ST_TERM: begin
                    if (game_req) begin
                        state_d     = ST_WIPE;
                        old_src_d   = SRC_TERM;
                        new_src_d   = SRC_GAME;
                        wipe_line_d = '0;
                    end
                end
                ST_GAME: begin
                    if (!game_req) begin
                        state_d     = ST_WIPE;
                        old_src_d   = SRC_GAME;
                        new_src_d   = SRC_TERM;
                        wipe_line_d = '0;
                    end
                end
                ST_WIPE: begin
                    // 11-bit sum so a large step cannot wrap past the last line
                    if (wipe_sum >= V_LIM11) begin
                        state_d     = (new_src_q == SRC_GAME) ? ST_GAME : ST_TERM;
                        wipe_line_d = '0;
                    end else begin
                        wipe_line_d = wipe_sum[9:0];
                    end
                end
            endcase
        end
    end

    always_comb begin
        pix_src = SRC_WELCOME;
        unique case (state_q)
            ST_WELCOME: pix_src = SRC_WELCOME;
            ST_TERM:    pix_src = SRC_TERM;
            ST_GAME:    pix_src = SRC_GAME;
            ST_WIPE:    pix_src = (v_addr < wipe_line_q) ? new_src_q : old_src_q;
        endcase
    end

    always_comb begin
        rgb_d = '0;
        if ((h_addr < H_LIM) && (v_addr < V_LIM)) begin
            case (pix_src)
                SRC_WELCOME: rgb_d = rgb_welcome;
                SRC_TERM:    rgb_d = rgb_term;
                SRC_GAME:    rgb_d = rgb_game;
                default:     rgb_d = '0;
            endcase
        end
    end

    always_comb begin
        active_src = SRC_WELCOME;
        unique case (state_q)
            ST_WELCOME: active_src = SRC_WELCOME;
            ST_TERM:    active_src = SRC_TERM;
            ST_GAME:    active_src = SRC_GAME;
            ST_WIPE:    active_src = old_src_q;
        endcase
    end

    assign busy    = (state_q == ST_WIPE);
    assign rgb_out = rgb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WELCOME;
            old_src_q   <= SRC_TERM;
            new_src_q   <= SRC_GAME;
            wipe_line_q <= '0;
            v_prev_q    <= '0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            old_src_q   <= old_src_d;
            new_src_q   <= new_src_d;
            wipe_line_q <= wipe_line_d;
            v_prev_q    <= v_addr;
            rgb_q       <= rgb_d;
        end
    end

endmodule
